// File: rtl/varredura_teclado_if.sv
`default_nettype none
// ============================================================================
// Module   : varredura_teclado_if
// Function : Keypad pins plus the one-hot key code handed to the decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface varredura_teclado_if;
  logic [2:0] kp_coluna_in;
  logic [2:0] kp_linha_out;
  logic [2:0] coluna_out;
  logic [2:0] linha_out;
  logic       tecla_valida_out;

  modport master (
    input  kp_coluna_in,
    output kp_linha_out,
    output coluna_out,
    output linha_out,
    output tecla_valida_out
  );

  modport slave (
    output kp_coluna_in,
    input  kp_linha_out,
    input  coluna_out,
    input  linha_out,
    input  tecla_valida_out
  );
endinterface
`default_nettype wire

// File: rtl/varredura_teclado.sv
`default_nettype none
// ============================================================================
// Module   : varredura_teclado
// Function : 3x3 keypad row scanner; reports one held key as a one-hot
//            column/row pair. Optional macro RELEASE_FILTER_EN debounces release.
// Revision : 1.0 - initial release
// ============================================================================
module varredura_teclado #(
  parameter int SETTLE_CYCLES = 4
) (
  input wire logic            clock_in,
  input wire logic            reset_in,
  varredura_teclado_if.master kp
);
  localparam logic [7:0] c_last      = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] c_row_first = 3'b100;

  typedef enum logic [0:0] {
    ST_SCAN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t     r_state, w_state_nx;
  logic [2:0] r_col_meta, r_col_sync;
  logic [7:0] r_count, w_count_nx;
  logic [2:0] r_linha, w_linha_nx;
  logic [2:0] r_coluna_out, w_coluna_out_nx;
  logic [2:0] r_linha_out, w_linha_out_nx;
  logic       r_valida, w_valida_nx;
  logic       w_one_hot, w_mismatch, w_release;
`ifdef RELEASE_FILTER_EN
  logic [7:0] r_miss, w_miss_nx;
`endif

  always_comb begin
    w_one_hot = (r_col_sync == 3'b001) || (r_col_sync == 3'b010) ||
                (r_col_sync == 3'b100);
  end

  // The reported column doubles as the captured column while locked.
  assign w_mismatch = (r_col_sync != r_coluna_out);

  always_comb begin
    w_state_nx      = r_state;
    w_count_nx      = r_count;
    w_linha_nx      = r_linha;
    w_coluna_out_nx = r_coluna_out;
    w_linha_out_nx  = r_linha_out;
    w_valida_nx     = r_valida;
    w_release       = 1'b0;
`ifdef RELEASE_FILTER_EN
    w_miss_nx       = r_miss;
`endif
    case (r_state)
      ST_SCAN: begin
        if (r_count == c_last) begin
          w_count_nx = 8'd0;
          if (w_one_hot) begin
            w_state_nx      = ST_LOCKED;
            w_coluna_out_nx = r_col_sync;
            w_linha_out_nx  = r_linha;
            w_valida_nx     = 1'b1;
`ifdef RELEASE_FILTER_EN
            w_miss_nx       = 8'd0;
`endif
          end else begin
            w_linha_nx = {r_linha[0], r_linha[2:1]};
          end
        end else begin
          w_count_nx = r_count + 8'd1;
        end
      end
      ST_LOCKED: begin
`ifdef RELEASE_FILTER_EN
        if (!w_mismatch) begin
          w_miss_nx = 8'd0;
        end else if (r_miss == c_last) begin
          w_miss_nx = 8'd0;
          w_release = 1'b1;
        end else begin
          w_miss_nx = r_miss + 8'd1;
        end
`else
        w_release = w_mismatch;
`endif
        if (w_release) begin
          w_state_nx      = ST_SCAN;
          w_linha_nx      = c_row_first;
          w_count_nx      = 8'd0;
          w_coluna_out_nx = 3'b000;
          w_linha_out_nx  = 3'b000;
          w_valida_nx     = 1'b0;
        end
      end
      default: w_state_nx = ST_SCAN;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state      <= ST_SCAN;
      r_col_meta   <= 3'b000;
      r_col_sync   <= 3'b000;
      r_count      <= 8'd0;
      r_linha      <= c_row_first;
      r_coluna_out <= 3'b000;
      r_linha_out  <= 3'b000;
      r_valida     <= 1'b0;
`ifdef RELEASE_FILTER_EN
      r_miss       <= 8'd0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_col_meta   <= kp.kp_coluna_in;
      r_col_sync   <= r_col_meta;
      r_count      <= w_count_nx;
      r_linha      <= w_linha_nx;
      r_coluna_out <= w_coluna_out_nx;
      r_linha_out  <= w_linha_out_nx;
      r_valida     <= w_valida_nx;
`ifdef RELEASE_FILTER_EN
      r_miss       <= w_miss_nx;
`endif
    end
  end

  assign kp.kp_linha_out     = r_linha;
  assign kp.coluna_out       = r_coluna_out;
  assign kp.linha_out        = r_linha_out;
  assign kp.tecla_valida_out = r_valida;
endmodule
`default_nettype wire

// File: tb/tb_varredura_teclado.sv
`default_nettype none
// ============================================================================
// Module   : tb_varredura_teclado
// Function : Bench for varredura_teclado: keypad matrix model, reference model
//            and directed key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_varredura_teclado;
  localparam int SETTLE = 4;
`ifdef RELEASE_FILTER_EN
  localparam int REL_LEN = SETTLE;
`else
  localparam int REL_LEN = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] keys = 9'd0;   // bit k-1 = key k held
  int         n_cmp = 0;
  int         n_bad = 0;

  varredura_teclado_if kp();

  varredura_teclado #(.SETTLE_CYCLES(SETTLE)) dut (
    .clock_in (clk),
    .reset_in (rst_n),
    .kp       (kp.master)
  );

  always #5 clk = ~clk;

  // Physical matrix: a driven row returns the columns of its held keys.
  function automatic logic [2:0] keypad(input logic [2:0] row, input logic [8:0] k);
    logic [2:0] c;
    c = 3'b000;
    for (int r = 0; r < 3; r++)
      if (row[2-r])
        for (int j = 0; j < 3; j++)
          if (k[r*3+j]) c = c | (3'b100 >> j);
    return c;
  endfunction

  always_comb kp.kp_coluna_in = keypad(kp.kp_linha_out, keys);

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: row index, cycles spent in the slot, locked column.
  int         m_row = 0;
  int         m_t = 0;
  int         m_miss = 0;
  bit         m_locked = 1'b0;
  logic [2:0] m_col = 3'b000;
  logic [2:0] m_s1 = 3'b000;
  logic [2:0] m_s2 = 3'b000;

  initial begin
    logic [2:0] pin;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_row = 0; m_t = 0; m_miss = 0; m_locked = 1'b0;
        m_col = 3'b000; m_s1 = 3'b000; m_s2 = 3'b000;
      end else begin
        pin = keypad(3'b100 >> m_row, keys);
        if (!m_locked) begin
          if (m_t == SETTLE - 1) begin
            m_t = 0;
            if ($countones(m_s2) == 1) begin
              m_locked = 1'b1; m_col = m_s2; m_miss = 0;
            end else begin
              m_row = (m_row + 1) % 3;
            end
          end else begin
            m_t++;
          end
        end else begin
          m_miss = (m_s2 != m_col) ? m_miss + 1 : 0;
          if (m_miss >= REL_LEN) begin
            m_locked = 1'b0; m_row = 0; m_t = 0; m_miss = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = pin;
      end
    end
  end

  initial begin
    logic [2:0] er;
    forever begin
      @(negedge clk);
      er = 3'b100 >> m_row;
      check("cyc_row", kp.kp_linha_out, er);
      check("cyc_col", kp.coluna_out, m_locked ? m_col : 3'b000);
      check("cyc_lin", kp.linha_out, m_locked ? er : 3'b000);
      check("cyc_val", {2'b00, kp.tecla_valida_out}, {2'b00, m_locked});
    end
  end

  task automatic wait_valid(input logic lvl, input int max, input string name);
    int n;
    n = 0;
    while (kp.tecla_valida_out !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, {2'b00, kp.tecla_valida_out}, {2'b00, lvl});
  endtask

  task automatic check_out(input string name, input logic [2:0] row,
                           input logic [2:0] col, input logic [2:0] lin, input logic val);
    check({name, "_row"}, kp.kp_linha_out, row);
    check({name, "_col"}, kp.coluna_out, col);
    check({name, "_lin"}, kp.linha_out, lin);
    check({name, "_val"}, {2'b00, kp.tecla_valida_out}, {2'b00, val});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_out("rst", 3'b100, 3'b000, 3'b000, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_100", kp.kp_linha_out, 3'b100);
    @(negedge clk);
    check("idle_010", kp.kp_linha_out, 3'b010);
    repeat (4) @(negedge clk);
    check("idle_001", kp.kp_linha_out, 3'b001);
    repeat (4) @(negedge clk);
    check("idle_wrap", kp.kp_linha_out, 3'b100);

    // Key 5 press, then release
    keys = 9'b000010000;
    wait_valid(1'b1, 14, "k5_lock");
    check_out("k5", 3'b010, 3'b010, 3'b010, 1'b1);
    repeat (3) @(negedge clk);
    check("k5_frozen", kp.kp_linha_out, 3'b010);
    keys = 9'd0;
    repeat (2) @(negedge clk);
    check_out("k5_hold", 3'b010, 3'b010, 3'b010, 1'b1);
`ifdef RELEASE_FILTER_EN
    repeat (4) @(negedge clk);
`else
    @(negedge clk);
`endif
    check_out("k5_rel", 3'b100, 3'b000, 3'b000, 1'b0);

    // Keys 7 and 9 on one row never lock
    keys = 9'b101000000;
    repeat (36) @(negedge clk);
    check_out("ghost", kp.kp_linha_out, 3'b000, 3'b000, 1'b0);
    keys = 9'd0;
    repeat (4) @(negedge clk);

    // Priority: keys 3 and 8 from a fresh scan
    rst_n = 1'b0;
    keys = 9'b010000100;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(1'b1, 14, "k3_lock");
    check_out("k3", 3'b100, 3'b001, 3'b100, 1'b1);
    keys = 9'b010000000;
    wait_valid(1'b0, 8, "k3_rel");
    wait_valid(1'b1, 20, "k8_lock");
    check_out("k8", 3'b001, 3'b010, 3'b001, 1'b1);

    // Asynchronous reset while locked
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 3'b100, 3'b000, 3'b000, 1'b0);
    keys = 9'd0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef RELEASE_FILTER_EN
    keys = 9'b000010000;
    wait_valid(1'b1, 14, "flt_lock");
    keys = 9'd0;
    repeat (2) @(negedge clk);
    keys = 9'b000010000;
    repeat (8) @(negedge clk);
    check_out("flt_bounce", 3'b010, 3'b010, 3'b010, 1'b1);
    keys = 9'd0;
    repeat (7) @(negedge clk);
    check_out("flt_rel", 3'b100, 3'b000, 3'b000, 1'b0);
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
`default_nettype wire
